tdc_multi_capture: RTL and testbench
====================================

// Module: tdc_multi_capture
// PURPOSE
//  Parametrised multi-channel TDC capture and readout controller. After an arm pulse it runs a
//  coarse cycle counter and latches each channel's delay-line thermometer taps on that channel's
//  first stop hit. It then encodes the fine code (bubble-tolerant ones-count) and presents
//  per-channel 32-bit result words through a byte-wide readout mux for the tt_um top-level pins.
// PARAMETERS
//  N_CH      4    number of stop channels (1..8)
//  N_DELAY   32   delay-line taps per channel (1..255)
//  COARSE_W  16   coarse counter width (1..16)
//  TIMEOUT   255  coarse count at which an armed measurement is abandoned (< 2**COARSE_W)
// PORTS
//  clk         in   1               system clock
//  rst_n       in   1               async reset, active-HIGH (asserted = 1)
//  arm         in   1               sync pulse; starts a measurement
//  hit_in      in   N_CH            async stop events, one per channel
//  therm_in    in   N_CH*N_DELAY    raw delay-line taps; channel c = [c*N_DELAY +: N_DELAY]
//  rd_ch       in   max(1,clog2 N_CH) readout channel select
//  rd_byte     in   2               readout byte select (0 = LSB)
//  data_out    out  8               selected result byte (combinational from registers)
//  busy        out  1               ARMED or ENCODE
//  done        out  1               results valid
//  timeout     out  1               last measurement ended by TIMEOUT
// BEHAVIOUR
//  - Reset: FSM=IDLE; coarse, all results, valid flags, busy, done and timeout = 0; data_out = 0.
//  - FSM:
//    - IDLE --arm--> ARMED: coarse=0; results, valid and timeout cleared.
//    - ARMED: coarse += 1 per clk, saturating at TIMEOUT.
//      -> ENCODE when all channels are valid, or when coarse == TIMEOUT (then timeout=1).
//    - ENCODE: one channel per clk, index 0..N_CH-1; -> DONE after N_CH cycles.
//    - DONE: done=1 -> ARMED on arm (same clear as from IDLE).
//    - arm is ignored in ARMED and ENCODE.
//  - hit_in: 2-FF synchroniser per channel, then rising-edge detect (compare with a 3rd FF).
//    - Hit level already high at arm: produces no edge; the channel waits for a fresh edge.
//  - First edge on channel c while ARMED:
//    - latch therm_in slice c (registered once in clk) and the current coarse value;
//    - set valid[c]; later edges on c are ignored until the next arm.
//  - Simultaneous edges on several channels in one cycle: all are captured with the same coarse.
//  - Edge in the same cycle coarse reaches TIMEOUT: captured, and timeout=1 still set.
//  - fine = popcount(latched taps), width clog2(N_DELAY+1); zero-extended to 8 bits.
//    - Tolerates thermometer bubbles; all-ones gives N_DELAY.
//  - Result word per channel, written in ENCODE: [31]=valid, [30:24]=0,
//    [23:8]=coarse zero-extended, [7:0]=fine. Invalid channel: word = 0.
//  - data_out = word[rd_ch][8*rd_byte +: 8]; rd_ch >= N_CH gives 0. Readout is legal in any
//    state, but only meaningful when done=1.
//  - Latency: final hit edge -> done=1 in 2 (sync) + 1 (edge) + 1 + N_CH clocks.
//  - Async reset mid-measurement aborts immediately to the reset state; no partial results kept.
// STRUCTURE
//  - Shared package tdc_pkg: FSM state enum (IDLE, ARMED, ENCODE, DONE), result-word field
//    offsets, function clog2_min1.
//  - Sub-module tdc_therm_encoder: combinational N_DELAY-bit popcount, output registered in the
//    parent.
// TESTING
//  - Reset with inputs toggling -> data_out=0, busy=0, done=0 for all rd_ch/rd_byte.
//  - arm; therm ch0 = 0x0000_00FF; hit ch0..3 at coarse 10,20,30,40
//    -> done; ch0 word = 0x8000_0A08; ch3 coarse field = 40.
//  - Bubble: therm = 0x0000_017F, single hit -> fine = 8.
//  - Only ch1 hit, then wait -> timeout=1 at coarse 255; ch1 valid; ch0/2/3 words = 0.
//  - ch0 and ch2 hit in the same cycle -> equal coarse fields; a second ch0 pulse leaves the
//    ch0 word unchanged.
//  - arm during ARMED ignored; reset asserted in ENCODE -> all outputs 0;
//    re-arm from DONE clears the old results.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM states, result-word field offsets and width helper for the TDC capture block
package tdc_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ENCODE, DONE} state_t;
    localparam int VALID_BIT = 31;
    localparam int COARSE_LSB = 8;
    localparam int FINE_LSB = 0;
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tdc_therm_encoder.sv
// tdc_therm_encoder: bubble-tolerant thermometer-to-binary fine code (ones count)
module tdc_therm_encoder #(
    parameter int N_DELAY = 32,
    parameter int FW = 6
) (
    input  logic [N_DELAY-1:0] taps,
    output logic [FW-1:0]      fine
);
    always_comb begin
        fine = '0;
        for (int i = 0; i < N_DELAY; i++) fine = fine + FW'(taps[i]);
    end
endmodule

// File: rtl/tdc_multi_capture.sv
// tdc_multi_capture: multi-channel TDC arm/capture/encode controller with byte-wide result readout
module tdc_multi_capture import tdc_pkg::*; #(
    parameter int N_CH = 4,
    parameter int N_DELAY = 32,
    parameter int COARSE_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic [N_CH-1:0]              hit_in,
    input  logic [N_CH*N_DELAY-1:0]      therm_in,
    input  logic [clog2_min1(N_CH)-1:0]  rd_ch,
    input  logic [1:0]                   rd_byte,
    output logic [7:0]                   data_out,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout
);
    localparam int CW = clog2_min1(N_CH);
    localparam int FW = $clog2(N_DELAY + 1);

    state_t state, state_nx;
    logic [N_CH-1:0] hit_s1, hit_s2, hit_s3, valid, cap;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_q [N_CH];
    logic [FW-1:0] fine_c [N_CH];
    logic [FW-1:0] fine_q [N_CH];
    logic [31:0] words [N_CH];
    logic [CW-1:0] idx;
    logic start, at_limit;

    assign cap = (state == ARMED) ? (hit_s2 & ~hit_s3 & ~valid) : '0;
    assign start = arm && (state == IDLE || state == DONE);
    assign at_limit = coarse == COARSE_W'(TIMEOUT);
    assign busy = state == ARMED || state == ENCODE;
    assign done = state == DONE;
    assign data_out = int'(rd_ch) < N_CH ? words[rd_ch][{rd_byte, 3'b000} +: 8] : 8'h00;

    // the fine code is taken at capture time, so only the encoded count is stored per channel
    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_enc
            tdc_therm_encoder #(.N_DELAY(N_DELAY), .FW(FW)) u_enc (
                .taps(therm_in[c*N_DELAY +: N_DELAY]),
                .fine(fine_c[c])
            );
        end
    endgenerate

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: state_nx = arm ? ARMED : state;
            ARMED:      state_nx = (&valid || at_limit) ? ENCODE : ARMED;
            ENCODE:     state_nx = idx == CW'(N_CH - 1) ? DONE : ENCODE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            {hit_s1, hit_s2, hit_s3, valid} <= '0;
            coarse <= '0;
            timeout <= 1'b0;
            idx <= '0;
            for (int i = 0; i < N_CH; i++) begin
                coarse_q[i] <= '0;
                fine_q[i] <= '0;
                words[i] <= '0;
            end
        end else begin
            state <= state_nx;
            hit_s1 <= hit_in;
            hit_s2 <= hit_s1;
            hit_s3 <= hit_s2;
            if (start) begin
                coarse <= '0;
                valid <= '0;
                timeout <= 1'b0;
                idx <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    coarse_q[i] <= '0;
                    fine_q[i] <= '0;
                    words[i] <= '0;
                end
            end else if (state == ARMED) begin
                coarse <= at_limit ? coarse : coarse + 1'b1;
                valid <= valid | cap;
                if (at_limit) timeout <= 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    if (cap[i]) begin
                        coarse_q[i] <= coarse;
                        fine_q[i] <= fine_c[i];
                    end
                end
            end else if (state == ENCODE) begin
                words[idx] <= valid[idx] ? ((32'(1) << VALID_BIT) | (32'(coarse_q[idx]) << COARSE_LSB)
                                            | (32'(fine_q[idx]) << FINE_LSB)) : '0;
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tdc_multi_capture.sv
// tb_tdc_multi_capture: randomized and directed self-checking bench against a cycle-offset reference model
module tb_tdc_multi_capture;
    localparam int N_CH = 4;
    localparam int N_DELAY = 32;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic arm = 1'b0;
    logic [N_CH-1:0] hit_in = '0;
    logic [N_CH*N_DELAY-1:0] therm_in = '0;
    logic [1:0] rd_ch = '0;
    logic [1:0] rd_byte = '0;
    logic [7:0] data_out;
    logic busy, done, timeout;

    int n_pass = 0;
    int n_chk = 0;
    int h [N_CH];
    logic [31:0] th [N_CH];
    bit pre1, second0, arm_mid;

    tdc_multi_capture #(.N_CH(N_CH), .N_DELAY(N_DELAY), .COARSE_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .hit_in(hit_in), .therm_in(therm_in),
        .rd_ch(rd_ch), .rd_byte(rd_byte), .data_out(data_out),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic read_word(input int ch, output logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            rd_ch = 2'(ch);
            rd_byte = 2'(b);
            #1;
            w[8*b +: 8] = data_out;
        end
    endtask

    // h[c] = clock offset after the arm edge at which channel c rises (-1 = never)
    task automatic measure(input string name);
        int t_done, hmax, exp_done;
        bit all_hit;
        logic [31:0] w, e;
        for (int c = 0; c < N_CH; c++) therm_in[c*N_DELAY +: N_DELAY] = th[c];
        if (pre1) hit_in[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        t_done = -1;
        for (int t = 0; t <= 400; t++) begin
            if (done) begin
                t_done = t;
                break;
            end
            for (int c = 0; c < N_CH; c++) if (h[c] == t) hit_in[c] = 1'b1;
            if (second0 && h[0] >= 0 && t == h[0] + 4) hit_in[0] = 1'b0;
            if (second0 && h[0] >= 0 && t == h[0] + 8) hit_in[0] = 1'b1;
            if (pre1 && t == 1) hit_in[1] = 1'b0;
            arm = arm_mid && t == 5;
            @(posedge clk);
            #1;
        end
        arm = 1'b0;
        all_hit = 1'b1;
        hmax = 0;
        for (int c = 0; c < N_CH; c++) begin
            if (h[c] < 0 || h[c] + 2 > TIMEOUT) all_hit = 1'b0;
            else if (h[c] > hmax) hmax = h[c];
        end
        exp_done = all_hit ? hmax + 4 + N_CH : TIMEOUT + 1 + N_CH;
        check({name, " done_lat"}, 32'(t_done), 32'(exp_done));
        check({name, " timeout"}, 32'(timeout), 32'(!all_hit));
        check({name, " busy"}, 32'(busy), 32'(0));
        for (int c = 0; c < N_CH; c++) begin
            e = (h[c] >= 0 && h[c] + 2 <= TIMEOUT) ?
                {1'b1, 7'b0, 16'(h[c] + 2), 8'($countones(th[c]))} : 32'h0;
            read_word(c, w);
            check($sformatf("%s word%0d", name, c), w, e);
        end
        hit_in = '0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            arm = 1'($urandom);
            hit_in = 4'($urandom);
            therm_in = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int c = 0; c < N_CH; c++) begin
            read_word(c, w);
            check($sformatf("rst word%0d", c), w, 32'h0);
        end
        check("rst busy", 32'(busy), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst timeout", 32'(timeout), 32'(0));
        arm = 1'b0;
        hit_in = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        {pre1, second0, arm_mid} = 3'b000;
        h = '{8, 18, 28, 38};
        th = '{32'h0000_00FF, 32'h0000_017F, 32'hDEAD_BEEF, 32'h0F0F_0F0F};
        measure("basic");

        h = '{-1, 20, -1, -1};
        th = '{32'hFFFF_FFFF, 32'h0000_017F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        measure("rearm_to");

        {pre1, second0, arm_mid} = 3'b111;
        h = '{12, 30, 12, 25};
        th = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'h0000_0003};
        measure("simul");

        {pre1, second0, arm_mid} = 3'b000;
        h = '{-1, 253, 254, -1};
        th = '{32'h1, 32'h0000_FFFF, 32'hFFFF_0000, 32'h3};
        measure("edge_to");

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                h[c] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
                th[c] = $urandom;
            end
            pre1 = (h[1] < 0 || h[1] >= 6) && $urandom_range(0, 1) == 1;
            second0 = $urandom_range(0, 1) == 1;
            arm_mid = $urandom_range(0, 1) == 1;
            measure($sformatf("rnd%0d", r));
        end

        {pre1, second0, arm_mid} = 3'b000;
        for (int c = 0; c < N_CH; c++) therm_in[c*N_DELAY +: N_DELAY] = 32'hFF;
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        hit_in = '1;
        repeat (7) @(posedge clk);
        #1;
        check("abort busy_before", 32'(busy), 32'(1));
        rst_n = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'(0));
        check("abort done", 32'(done), 32'(0));
        check("abort timeout", 32'(timeout), 32'(0));
        for (int c = 0; c < N_CH; c++) begin
            read_word(c, w);
            check($sformatf("abort word%0d", c), w, 32'h0);
        end
        hit_in = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
